// File: rtl/regfile_pkg.sv
// Shared constants for the register file writeback path, plus the
// round-robin pointer advance used by the writeback arbiter.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  // Pointer value after a grant to index g: one past the winner, wrapping to 0.
  function automatic int unsigned rr_next_ptr(input int unsigned g, input int unsigned num_req);
    return (g == num_req - 1) ? 32'd0 : g + 32'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter (module rr_arbiter). The search starts at ptr and
// wraps modulo NUM_REQ. The first requester found wins. gnt is one-hot, or all zero
// when there is no request. gnt_idx is the binary index of the winner, and 0 when idle.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  // Walk the candidates in priority order starting at ptr, and keep the first valid one.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = found ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the regfile write port among NUM_REQ writeback sources.
// The winner's rd and wdata are registered onto the port one cycle after the handshake.
// Writes to x0 are acknowledged, but we stays low.
// Optional feature: define RF_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
// conflict_cnt counts the cycles in which two or more sources are valid at once.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rd,
  output logic                      we,
  output logic [DATA_W-1:0]         wdata
`ifdef RF_CONFLICT_CNT_EN
  , output logic [31:0]             conflict_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               grant;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_wdata;
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Qualify the grant with reset. Select the winner's payload and compute the next pointer and port state.
  always_comb begin
    req_ready = reset ? '0 : gnt;
    grant     = |req_ready;
    sel_rd    = req_rd[32'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[32'(gnt_idx)*DATA_W +: DATA_W];
    rr_ptr_d  = rr_ptr_q;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    if (grant) begin
      rr_ptr_d = PTR_W'(rr_next_ptr(32'(gnt_idx), NUM_REQ));
      rd_d     = sel_rd;
      wdata_d  = sel_wdata;
      we_d     = (sel_rd != '0);
    end
  end

  // Pointer register and registered regfile write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  assign rd    = rd_q;
  assign we    = we_q;
  assign wdata = wdata_q;

`ifdef RF_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  // Count contention cycles, saturating at all-ones.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (($countones(req_valid) >= 2) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  // Contention counter register.
  always_ff @(posedge clk) begin
    if (reset) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with NUM_REQ=2.
// A small regfile model listens to the write port, so the bench can confirm end-to-end writes.
// conflict_cnt is checked only when RF_CONFLICT_CNT_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rd;
  logic                      we;
  logic [DATA_W-1:0]         wdata;
`ifdef RF_CONFLICT_CNT_EN
  logic [31:0]               conflict_cnt;
`endif

  logic [ADDR_W-1:0] rd0_v, rd1_v;
  logic [DATA_W-1:0] wd0_v, wd1_v;
  assign req_rd    = {rd1_v, rd0_v};
  assign req_wdata = {wd1_v, wd0_v};

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rd        (rd),
    .we        (we),
    .wdata     (wdata)
`ifdef RF_CONFLICT_CNT_EN
    , .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file driven by the DUT write port; x0 reads as zero.
  logic [DATA_W-1:0] rf [32];
  always @(posedge clk) begin
    if (we && rd != '0) rf[rd] <= wdata;
  end

  function automatic logic [DATA_W-1:0] rf_read(input int addr);
    return (addr == 0) ? '0 : rf[addr];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end else begin
      $display("check %s ok value=%0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus tables for the post-reset contention phase.
  logic [1:0]        exp_rdy_tab [4];
  logic [ADDR_W-1:0] exp_rd_tab  [4];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_rdy_tab = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd_tab  = '{5'd1, 5'd2, 5'd1, 5'd2};
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1;
    req_valid = '0;
    rd0_v = '0; rd1_v = '0; wd0_v = '0; wd1_v = '0;

    // Reset: no grant while reset is high, even with requests pending.
    tick();
    req_valid = 2'b11; rd0_v = 5'd7; rd1_v = 5'd8; wd0_v = 32'h7; wd1_v = 32'h8;
    #1;
    check_eq("rst_ready", req_ready, 2'b00);
    tick();
    check_eq("rst_we", we, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_wdata", wdata, 0);

    // Single source 0 write to x5.
    reset = 1'b0;
    req_valid = 2'b01; rd0_v = 5'd5; wd0_v = 32'hDEAD_BEEF;
    #1;
    check_eq("single_ready", req_ready, 2'b01);
    tick();
    check_eq("single_we", we, 1);
    check_eq("single_rd", rd, 5);
    check_eq("single_wdata", wdata, 32'hDEAD_BEEF);
    req_valid = 2'b00;
    #1;
    check_eq("idle_ready", req_ready, 2'b00);
    tick();
    check_eq("single_rf_x5", rf_read(5), 32'hDEAD_BEEF);
    check_eq("idle1_we", we, 0);
    check_eq("idle1_rd_hold", rd, 5);
    check_eq("idle1_wdata_hold", wdata, 32'hDEAD_BEEF);
    tick();
    check_eq("idle2_we", we, 0);
    tick();
    check_eq("idle3_we", we, 0);

    // Pointer held at 1 across idle: source 1 (an x0 write) wins over source 0.
    req_valid = 2'b11; rd0_v = 5'd3; wd0_v = 32'h3333_0003; rd1_v = 5'd0; wd1_v = 32'h1234;
    #1;
    check_eq("x0_ready", req_ready, 2'b10);
    tick();
    check_eq("x0_we", we, 0);
    check_eq("x0_rd", rd, 0);
    check_eq("x0_wdata", wdata, 32'h1234);
    req_valid = 2'b01;
    #1;
    check_eq("after_x0_ready", req_ready, 2'b01);
    tick();
    check_eq("after_x0_we", we, 1);
    check_eq("after_x0_rd", rd, 3);
    req_valid = 2'b00;
    tick();
    check_eq("rf_x3", rf_read(3), 32'h3333_0003);
    check_eq("rf_x0", rf_read(0), 0);

    // Contention, then a reset pulse while rr_ptr=1.
    req_valid = 2'b11; rd0_v = 5'd1; wd0_v = 32'hA1; rd1_v = 5'd2; wd1_v = 32'hB2;
    #1;
    check_eq("cont_pre_ready0", req_ready, 2'b10);
    tick();
    check_eq("cont_pre_rd0", rd, 2);
    check_eq("cont_pre_ready1", req_ready, 2'b01);
    tick();
    check_eq("cont_pre_rd1", rd, 1);
    reset = 1'b1;
    #1;
    check_eq("midrst_ready", req_ready, 2'b00);
    tick();
    check_eq("midrst_we", we, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("cont_ready%0d", i), req_ready, exp_rdy_tab[i]);
      tick();
      check_eq($sformatf("cont_we%0d", i), we, 1);
      check_eq($sformatf("cont_rd%0d", i), rd, exp_rd_tab[i]);
    end
    req_valid = 2'b00;
    tick();

`ifdef RF_CONFLICT_CNT_EN
    // Contention counter: 10 cycles with both sources valid, then 5 cycles with only req0 valid.
    reset = 1'b1;
    tick();
    check_eq("cnt_reset", conflict_cnt, 0);
    reset = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    req_valid = 2'b00;
    tick();
    check_eq("cnt_value", conflict_cnt, 10);
`else
    $display("note conflict_cnt port not built in this configuration");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
